// File: rtl/histo_stream_receiver.sv
// histo_stream_receiver: oversampling receiver for the histogram serial stream with framing checks
module histo_stream_receiver #(
    parameter int WORD_BITS   = 32,
    parameter int BINS        = 1024,
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_clk_i,
    input  logic                 spi_mosi_i,
    output logic                 word_valid_o,
    output logic [WORD_BITS-1:0] word_data_o,
    output logic [9:0]           bin_o,
    output logic                 frame_done_o,
    output logic [7:0]           frame_id_o,
    output logic [33:0]          frame_sum_o,
    output logic                 err_seq_o,
    output logic                 err_fmt_o,
    output logic                 err_short_o,
    output logic                 busy_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    localparam int BW = $clog2(WORD_BITS);
    localparam int CW = (BINS > 1) ? $clog2(BINS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   clk_prev;
    logic                   rise;
    logic                   bit_in;
    logic                   timeout;
    logic [0:0]             state;
    logic [BW-1:0]          bit_cnt;
    logic [CW-1:0]          word_cnt;
    logic [TW-1:0]          idle_cnt;
    logic [WORD_BITS-1:0]   shift_reg;
    logic                   word_done;
    logic                   last_word;
    logic                   have_prev;
    logic [7:0]             cur_id;
    logic [33:0]            acc;

    assign rise    = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign bit_in  = mosi_sync[SYNC_STAGES-1];
    assign timeout = (state == RECV) && !rise && (idle_cnt >= TW'(TIMEOUT - 1));
    assign busy_o  = (state == RECV);

    // bring the serial clock and data into the clk domain and keep the previous clock sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            mosi_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    // deserialise words, tag bins, accumulate the frame and raise framing errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            idle_cnt     <= '0;
            shift_reg    <= '0;
            word_done    <= 1'b0;
            last_word    <= 1'b0;
            have_prev    <= 1'b0;
            cur_id       <= '0;
            acc          <= '0;
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            bin_o        <= '0;
            frame_done_o <= 1'b0;
            frame_id_o   <= '0;
            frame_sum_o  <= '0;
            err_seq_o    <= 1'b0;
            err_fmt_o    <= 1'b0;
            err_short_o  <= 1'b0;
        end else begin
            word_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
            err_seq_o    <= 1'b0;
            err_fmt_o    <= 1'b0;
            err_short_o  <= 1'b0;
            idle_cnt     <= (rise || state == IDLE) ? '0 :
                            (idle_cnt < TW'(TIMEOUT - 1)) ? idle_cnt + 1'b1 : idle_cnt;
            if (timeout) begin
                state       <= IDLE;
                err_short_o <= 1'b1;
                bit_cnt     <= '0;
                word_cnt    <= '0;
                shift_reg   <= '0;
                acc         <= '0;
                word_done   <= 1'b0;
                last_word   <= 1'b0;
            end else begin
                word_done <= rise && (bit_cnt == BW'(WORD_BITS - 1));
                last_word <= word_done && (word_cnt == CW'(BINS - 1));
                if (word_done) begin
                    word_valid_o <= 1'b1;
                    word_data_o  <= shift_reg;
                    bin_o        <= 10'(word_cnt) + 10'h3FF;
                    err_fmt_o    <= (word_cnt != '0) && (shift_reg[31:24] != 8'h00);
                    cur_id       <= (word_cnt == '0) ? shift_reg[31:24] : cur_id;
                    acc          <= ((word_cnt == '0) ? 34'd0 : acc) + 34'(shift_reg[23:0]);
                    word_cnt     <= (word_cnt == CW'(BINS - 1)) ? '0 : word_cnt + 1'b1;
                end
                if (last_word) begin
                    state        <= IDLE;
                    frame_done_o <= 1'b1;
                    frame_id_o   <= cur_id;
                    frame_sum_o  <= acc;
                    err_seq_o    <= have_prev && (cur_id != frame_id_o + 8'd1);
                    have_prev    <= 1'b1;
                end
                if (rise) begin
                    state     <= RECV;
                    shift_reg <= {shift_reg[WORD_BITS-2:0], bit_in};
                    bit_cnt   <= (bit_cnt == BW'(WORD_BITS - 1)) ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_histo_stream_receiver.sv
// tb_histo_stream_receiver: frame-level checks of the histogram stream receiver against a reference model
module tb_histo_stream_receiver;
    localparam int BINS    = 8;
    localparam int TIMEOUT = 64;
    localparam int SYNC    = 2;

    typedef struct {
        logic [7:0]  id;
        int          pat;
        int          n;
        int          fmt_word;
        logic [7:0]  fmt_val;
        int          gap;
        logic [33:0] sum;
        logic        seq;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [9:0]  bin;
        logic        fmt;
        int          lat;
    } wev_t;

    typedef struct {
        logic [7:0]  id;
        logic [33:0] sum;
        logic        seq;
    } fev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        word_valid;
    logic [31:0] word_data;
    logic [9:0]  bin;
    logic        frame_done;
    logic [7:0]  frame_id;
    logic [33:0] frame_sum;
    logic        err_seq;
    logic        err_fmt;
    logic        err_short;
    logic        busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   short_cnt = 0;
    int   stray_cnt = 0;
    int   rise_q[$];
    wev_t wq[$];
    fev_t fq[$];
    logic       prev_wv = 1'b0;
    logic [9:0] prev_bin = '0;

    logic        have_prev = 1'b0;
    logic [7:0]  prev_id = '0;
    logic [7:0]  last_id = '0;
    logic [33:0] last_sum = '0;

    histo_stream_receiver #(.WORD_BITS(32), .BINS(BINS), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .spi_clk_i(spi_clk), .spi_mosi_i(spi_mosi),
        .word_valid_o(word_valid), .word_data_o(word_data), .bin_o(bin),
        .frame_done_o(frame_done), .frame_id_o(frame_id), .frame_sum_o(frame_sum),
        .err_seq_o(err_seq), .err_fmt_o(err_fmt), .err_short_o(err_short), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record output events; strobes seen outside their companion strobe are strays
    always @(negedge clk) begin
        if (!reset) begin
            if (word_valid)
                wq.push_back('{word_data, bin, err_fmt, (rise_q.size() > 0) ? cyc - rise_q.pop_front() : -1});
            else if (err_fmt)
                stray_cnt++;
            if (frame_done) begin
                fq.push_back('{frame_id, frame_sum, err_seq});
                if (!(prev_wv && prev_bin == 10'(BINS - 2))) stray_cnt++;
            end else if (err_seq)
                stray_cnt++;
            if (err_short) short_cnt++;
            prev_wv  = word_valid;
            prev_bin = bin;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 31; i >= 32 - nbits; i--) begin
            @(negedge clk);
            spi_clk  = 1'b0;
            spi_mosi = w[i];
            @(negedge clk);
            @(negedge clk);
            spi_clk = 1'b1;
            if (i == 0) rise_q.push_back(cyc);
            @(negedge clk);
        end
    endtask

    task automatic clear_queues();
        wq.delete();
        fq.delete();
        rise_q.delete();
        short_cnt = 0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [31:0] w [BINS];
        logic [23:0] cnt;
        logic [7:0]  up;
        logic [33:0] exp_sum;
        logic        exp_seq;
        wev_t        e;
        fev_t        f;
        exp_sum = '0;
        for (int i = 0; i < BINS; i++) begin
            cnt = (v.pat == 0) ? 24'd1 : (v.pat == 1) ? ((i == 0) ? 24'd7 : 24'(i - 1)) : 24'($urandom);
            up  = (i == 0) ? v.id : (i == v.fmt_word) ? v.fmt_val : 8'h00;
            w[i] = {up, cnt};
            exp_sum += 34'(cnt);
        end
        exp_seq = have_prev && (v.id != 8'(prev_id + 8'd1));
        if (v.pat != 2) begin
            exp_sum = v.sum;
            exp_seq = v.seq;
        end
        clear_queues();
        for (int i = 0; i < v.n; i++) begin
            send_word(w[i], 32);
            if (i == 2 && v.gap > 0) begin
                @(negedge clk);
                spi_clk = 1'b0;
                repeat (v.gap) @(negedge clk);
            end
        end
        @(negedge clk);
        spi_clk = 1'b0;
        repeat ((v.n == BINS) ? 20 : TIMEOUT + 20) @(negedge clk);
        check({tag, " word_count"}, 128'(wq.size()), 128'(v.n));
        for (int i = 0; i < v.n && i < wq.size(); i++) begin
            e = wq[i];
            check($sformatf("%s word%0d data/bin/fmt/lat", tag, i), {e.data, e.bin, e.fmt, e.lat},
                  {w[i], (i == 0) ? 10'h3FF : 10'(i - 1), (i != 0) && (w[i][31:24] != 8'h00), SYNC + 2});
        end
        if (v.n == BINS) begin
            f = (fq.size() > 0) ? fq[0] : '{8'h00, 34'd0, 1'b0};
            check({tag, " frame_done count/id/sum/seq"}, {32'(fq.size()), f.id, f.sum, f.seq},
                  {32'd1, v.id, exp_sum, exp_seq});
            check({tag, " err_short count"}, 128'(short_cnt), 128'd0);
            have_prev = 1'b1;
            prev_id   = v.id;
            last_id   = v.id;
            last_sum  = exp_sum;
        end else begin
            check({tag, " abort short/done count"}, {32'(short_cnt), 32'(fq.size())}, {32'd1, 32'd0});
            check({tag, " held id/sum"}, {frame_id, frame_sum}, {last_id, last_sum});
        end
        check({tag, " busy after"}, 128'(busy), 128'd0);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t r;
        tbl[0] = '{8'h05, 0, BINS, -1, 8'h00, 0, 34'd8, 1'b0};
        tbl[1] = '{8'h06, 1, BINS, -1, 8'h00, 0, 34'd28, 1'b0};
        tbl[2] = '{8'h07, 0, BINS, 5, 8'h3C, 0, 34'd8, 1'b0};
        tbl[3] = '{8'h08, 0, 5, -1, 8'h00, 0, 34'd0, 1'b0};
        tbl[4] = '{8'h08, 1, BINS, -1, 8'h00, TIMEOUT - 8, 34'd28, 1'b0};
        tbl[5] = '{8'hFE, 0, BINS, -1, 8'h00, 0, 34'd8, 1'b0};
        tbl[6] = '{8'hFF, 1, BINS, -1, 8'h00, 0, 34'd28, 1'b0};
        tbl[7] = '{8'h00, 0, BINS, -1, 8'h00, 0, 34'd8, 1'b0};
        tbl[8] = '{8'h02, 0, BINS, -1, 8'h00, 0, 34'd8, 1'b1};

        repeat (3) @(negedge clk);
        check("reset outputs", {word_valid, word_data, bin, frame_done, frame_id, frame_sum,
                                err_seq, err_fmt, err_short, busy}, '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 5; t++) run_frame(tbl[t], $sformatf("row%0d", t));

        // abandon a frame part-way through a word with reset
        clear_queues();
        send_word({8'h09, 24'd1}, 32);
        send_word(32'd1, 32);
        send_word(32'd1, 32);
        send_word(32'hFFFF_FFFF, 10);
        check("busy mid-frame", 128'(busy), 128'd1);
        @(negedge clk);
        reset   = 1'b1;
        spi_clk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("outputs in reset", {word_valid, word_data, bin, frame_done, frame_id, frame_sum,
                                       err_seq, err_fmt, err_short, busy}, '0);
        end
        reset = 1'b0;
        clear_queues();
        have_prev = 1'b0;
        last_id   = '0;
        last_sum  = '0;
        repeat (3) @(negedge clk);

        for (int t = 5; t < 9; t++) run_frame(tbl[t], $sformatf("row%0d", t));

        for (int k = 0; k < 10; k++) begin
            r.id       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(prev_id + 8'd1);
            r.pat      = 2;
            r.n        = ($urandom_range(0, 4) == 0) ? $urandom_range(1, BINS - 1) : BINS;
            r.fmt_word = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BINS - 1) : -1;
            r.fmt_val  = 8'($urandom_range(1, 255));
            r.gap      = 0;
            r.sum      = '0;
            r.seq      = 1'b0;
            run_frame(r, $sformatf("rand%0d", k));
        end

        check("stray strobes", 128'(stray_cnt), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
